x_mem_2048x2_player: RTL

Playback controller for the 2048x2 single-port sample memory, acting as its reader side. It owns the memory port and exposes host writes to the memory only while idle. On command it reads samples from address 0 up to a programmed last address, once or looping. Each 2-bit sample is presented to the DAC front end for a programmable number of cycles.

---
 rtl/x_mem_2048x2_player_if.sv | 18 +
 rtl/x_mem_2048x2_player.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/x_mem_2048x2_player_if.sv
// Host write bus for the 2048x2 sample memory player.
// The host side uses the master modport and the player uses the slave modport.
//   wr_valid : host write request
//   wr_addr  : host write address
//   wr_data  : host write data
//   wr_ready : player accepts the write this cycle (high only while idle)
interface x_mem_2048x2_player_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 2
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/x_mem_2048x2_player.sv
// Playback controller for the 2048x2 single-port sample memory (reader side).
// It owns the memory port. While idle, host writes pass straight through to the
// memory. On start it plays addresses 0..last, once or looping, and presents
// each sample to the DAC for max(div,2)+1 cycles.
//
// Optional feature: define PLAYER_MUTE_ON_IDLE_EN to force o_sample to 0
// whenever playback returns to idle (stop, natural end, reset).
//
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start, i_stop   : start pulse (idle only), abort pulse
//   i_loop, i_last,
//   i_div             : loop enable, last address, period-1 (latched at start)
//   wr                : host write bus (slave modport)
//   o_mem_addr/we/wdata, i_mem_rdata : memory port (read data one cycle late)
//   o_sample, o_sample_stb : DAC sample and new-value strobe
//   o_busy, o_done    : playback active, end-of-play pulse (non-loop only)
module x_mem_2048x2_player #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 2,
  parameter int DIV_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_loop,
  input  logic [ADDR_W-1:0]      i_last,
  input  logic [DIV_W-1:0]       i_div,
  x_mem_2048x2_player_if.slave   wr,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic                   o_mem_we,
  output logic [DATA_W-1:0]      o_mem_wdata,
  input  logic [DATA_W-1:0]      i_mem_rdata,
  output logic [DATA_W-1:0]      o_sample,
  output logic                   o_sample_stb,
  output logic                   o_busy,
  output logic                   o_done
);

`ifdef PLAYER_MUTE_ON_IDLE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt;
  logic              loop_q;
  logic              end_q;
  logic              done_q;
  logic [DATA_W-1:0] sample_q;

  // The memory returns data one cycle after the address, so the strobe cycle
  // shows the read data directly and sample_q keeps it for the rest of the
  // period. HOLD lasts div_q cycles; its last cycle already has the next
  // address on the bus, which keeps strobes exactly one period apart.
  // end_q marks that the final non-loop sample has been strobed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      last_q   <= '0;
      div_q    <= '0;
      cnt      <= '0;
      loop_q   <= 1'b0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            last_q <= i_last;
            div_q  <= (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;
            loop_q <= i_loop;
            ptr    <= '0;
            end_q  <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (i_stop) begin
            state <= S_IDLE;
            if (MUTE) sample_q <= '0;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (i_stop) begin
            state    <= S_IDLE;
            sample_q <= MUTE ? '0 : i_mem_rdata;
          end else begin
            sample_q <= i_mem_rdata;
            cnt      <= div_q - DIV_W'(1);
            state    <= S_HOLD;
            if (ptr == last_q) begin
              if (loop_q) ptr <= '0;
              else        end_q <= 1'b1;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (i_stop) begin
            state <= S_IDLE;
            if (MUTE) sample_q <= '0;
          end else if (cnt == '0) begin
            if (end_q) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
              if (MUTE) sample_q <= '0;
            end else begin
              state <= S_CAPTURE;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // While idle the host owns the memory port combinationally; while busy the
  // port is a read of the playback pointer.
  always_comb begin
    o_sample_stb = (state == S_CAPTURE);
    o_sample     = o_sample_stb ? i_mem_rdata : sample_q;
    o_busy       = (state != S_IDLE);
    o_done       = done_q;
    wr.wr_ready  = (state == S_IDLE);
    o_mem_we     = (state == S_IDLE) && wr.wr_valid;
    o_mem_addr   = (state == S_IDLE) ? wr.wr_addr : ptr;
    o_mem_wdata  = (state == S_IDLE) ? wr.wr_data : '0;
  end

endmodule
